// File: rtl/ball_pkg.sv
// rtl/ball_pkg.sv - shared ball geometry, fixed-point widths and state type
package ball_pkg;
    localparam int FIXED_POINT_BITS = 6;
    localparam int BALL_SIZE        = 32;
    localparam int POS_W            = 17;
    localparam int SPEED_W          = 11;
    localparam int PIX_W            = 11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MOVING   = 2'd1,
        POCKETED = 2'd2
    } ball_state_t;

    function automatic logic signed [SPEED_W-1:0] clamp_speed(
        input logic signed [SPEED_W-1:0] s,
        input int                        max_speed
    );
        if (int'(s) > max_speed)
            return SPEED_W'(max_speed);
        else if (int'(s) < -max_speed)
            return SPEED_W'(-max_speed);
        else
            return s;
    endfunction
endpackage

// File: rtl/ball_axis_integrator.sv
// rtl/ball_axis_integrator.sv - one axis: add speed, bounce off bounds, apply friction
module ball_axis_integrator
    import ball_pkg::*;
#(
    parameter int LOW      = 40,
    parameter int HIGH     = 568,
    parameter int FRICTION = 2
) (
    input  logic signed [POS_W-1:0]   pos,
    input  logic signed [SPEED_W-1:0] speed,
    output logic signed [POS_W-1:0]   pos_next,
    output logic signed [SPEED_W-1:0] speed_next,
    output logic                      bounce
);
    localparam logic signed [POS_W:0]   LOW_FP   = (POS_W+1)'(LOW << FIXED_POINT_BITS);
    localparam logic signed [POS_W:0]   HIGH_FP  = (POS_W+1)'(HIGH << FIXED_POINT_BITS);
    // first subpixel value whose integer pixel lies beyond HIGH
    localparam logic signed [POS_W:0]   ABOVE_FP = (POS_W+1)'((HIGH + 1) << FIXED_POINT_BITS);
    localparam logic signed [SPEED_W-1:0] FRIC   = SPEED_W'(FRICTION);

    logic signed [POS_W:0]   sum;
    logic signed [SPEED_W-1:0] v;

    always_comb begin
        sum      = {pos[POS_W-1], pos} + {{(POS_W+1-SPEED_W){speed[SPEED_W-1]}}, speed};
        v        = speed;
        bounce   = 1'b0;
        pos_next = sum[POS_W-1:0];
        if (sum < LOW_FP) begin
            pos_next = POS_W'(LOW_FP);
            v        = -speed;
            bounce   = 1'b1;
        end else if (sum >= ABOVE_FP) begin
            pos_next = POS_W'(HIGH_FP);
            v        = -speed;
            bounce   = 1'b1;
        end
        // friction shrinks magnitude toward zero and never flips the sign
        if (v > FRIC)
            speed_next = v - FRIC;
        else if (v < -FRIC)
            speed_next = v + FRIC;
        else
            speed_next = '0;
    end
endmodule

// File: rtl/ball_move.sv
// rtl/ball_move.sv - billiard ball motion FSM with per-frame integration and pocketing
module ball_move
    import ball_pkg::*;
#(
    parameter int INITIAL_X    = 300,
    parameter int INITIAL_Y    = 200,
    parameter int TABLE_LEFT   = 40,
    parameter int TABLE_RIGHT  = 600,
    parameter int TABLE_TOP    = 40,
    parameter int TABLE_BOTTOM = 440,
    parameter int FRICTION     = 2,
    parameter int MAX_SPEED    = 1023
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      startOfFrame,
    input  logic                      strike,
    input  logic signed [SPEED_W-1:0] strikeSpeedX,
    input  logic signed [SPEED_W-1:0] strikeSpeedY,
    input  logic                      pocket,
    input  logic                      respawn,
    output logic signed [PIX_W-1:0]   ballTopLeftPosX,
    output logic signed [PIX_W-1:0]   ballTopLeftPosY,
    output logic                      ballMoving,
    output logic                      ballVisible,
    output logic                      wallHit
);
    localparam logic signed [POS_W-1:0] INIT_X_FP = POS_W'(INITIAL_X << FIXED_POINT_BITS);
    localparam logic signed [POS_W-1:0] INIT_Y_FP = POS_W'(INITIAL_Y << FIXED_POINT_BITS);

    ball_state_t               state;
    logic signed [POS_W-1:0]   pos_x, pos_y, nx, ny;
    logic signed [SPEED_W-1:0] spd_x, spd_y, nsx, nsy, load_x, load_y;
    logic                      bx, by;

    ball_axis_integrator #(
        .LOW(TABLE_LEFT), .HIGH(TABLE_RIGHT - BALL_SIZE), .FRICTION(FRICTION)
    ) u_axis_x (
        .pos(pos_x), .speed(spd_x), .pos_next(nx), .speed_next(nsx), .bounce(bx)
    );

    ball_axis_integrator #(
        .LOW(TABLE_TOP), .HIGH(TABLE_BOTTOM - BALL_SIZE), .FRICTION(FRICTION)
    ) u_axis_y (
        .pos(pos_y), .speed(spd_y), .pos_next(ny), .speed_next(nsy), .bounce(by)
    );

    assign load_x = clamp_speed(strikeSpeedX, MAX_SPEED);
    assign load_y = clamp_speed(strikeSpeedY, MAX_SPEED);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state   <= IDLE;
            pos_x   <= INIT_X_FP;
            pos_y   <= INIT_Y_FP;
            spd_x   <= '0;
            spd_y   <= '0;
            wallHit <= 1'b0;
        end else begin
            wallHit <= 1'b0;
            case (state)
                IDLE: begin
                    if (pocket) begin
                        spd_x <= '0;
                        spd_y <= '0;
                        state <= POCKETED;
                    end else if (strike) begin
                        // a coincident frame pulse is swallowed by the strike
                        spd_x <= load_x;
                        spd_y <= load_y;
                        state <= (load_x == '0 && load_y == '0) ? IDLE : MOVING;
                    end
                end
                MOVING: begin
                    if (pocket) begin
                        spd_x <= '0;
                        spd_y <= '0;
                        state <= POCKETED;
                    end else if (startOfFrame) begin
                        pos_x   <= nx;
                        pos_y   <= ny;
                        spd_x   <= nsx;
                        spd_y   <= nsy;
                        wallHit <= bx | by;
                        if (nsx == '0 && nsy == '0)
                            state <= IDLE;
                    end
                end
                POCKETED: begin
                    if (respawn) begin
                        pos_x <= INIT_X_FP;
                        pos_y <= INIT_Y_FP;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ballTopLeftPosX = PIX_W'(pos_x >>> FIXED_POINT_BITS);
    assign ballTopLeftPosY = PIX_W'(pos_y >>> FIXED_POINT_BITS);
    assign ballMoving      = (state == MOVING);
    assign ballVisible     = (state != POCKETED);
endmodule

// File: tb/tb_ball_move.sv
// tb/tb_ball_move.sv - directed scoreboard bench for ball_move
module tb_ball_move;
    logic               clk = 1'b0;
    logic               resetN;
    logic               startOfFrame, strike, pocket, respawn, strike2;
    logic signed [10:0] sx, sy, sx2, sy2;
    logic signed [10:0] px, py, px2, py2;
    logic               moving, visible, wall, moving2, visible2, wall2;
    logic               zero = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    integer exp_q[$];
    string  tag_q[$];

    int m_px, m_py, m_vx, m_vy;
    bit m_moving, m_pocketed;

    always #5 clk = ~clk;

    ball_move dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .strike(strike),
        .strikeSpeedX(sx), .strikeSpeedY(sy), .pocket(pocket), .respawn(respawn),
        .ballTopLeftPosX(px), .ballTopLeftPosY(py), .ballMoving(moving),
        .ballVisible(visible), .wallHit(wall)
    );

    ball_move #(.INITIAL_X(50)) dut2 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .strike(strike2),
        .strikeSpeedX(sx2), .strikeSpeedY(sy2), .pocket(zero), .respawn(zero),
        .ballTopLeftPosX(px2), .ballTopLeftPosY(py2), .ballMoving(moving2),
        .ballVisible(visible2), .wallHit(wall2)
    );

    task automatic push(input string tag, input integer v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input integer obs);
        string  t;
        integer e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        n_checks++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
        end
    endtask

    function automatic int clampv(input int s);
        if (s > 1023) return 1023;
        if (s < -1023) return -1023;
        return s;
    endfunction

    task automatic axis(inout int p, inout int v, input int lo, input int hi, output bit b);
        int s;
        s = p + v;
        b = 0;
        if (s < lo * 64) begin
            p = lo * 64; v = -v; b = 1;
        end else if ((s >>> 6) > hi) begin
            p = hi * 64; v = -v; b = 1;
        end else begin
            p = s;
        end
        if (v > 2) v -= 2;
        else if (v < -2) v += 2;
        else v = 0;
    endtask

    task automatic model_reset();
        m_px = 300 * 64; m_py = 200 * 64; m_vx = 0; m_vy = 0;
        m_moving = 0; m_pocketed = 0;
    endtask

    task automatic check_pos(input string tag);
        push({tag, "_x"}, m_px >>> 6);
        push({tag, "_y"}, m_py >>> 6);
        push({tag, "_moving"}, m_moving);
        push({tag, "_visible"}, !m_pocketed);
        check(px); check(py); check(moving); check(visible);
    endtask

    task automatic do_frame(input string tag);
        bit bx, by;
        bx = 0; by = 0;
        if (m_moving) begin
            axis(m_px, m_vx, 40, 568, bx);
            axis(m_py, m_vy, 40, 408, by);
            if (m_vx == 0 && m_vy == 0) m_moving = 0;
        end
        push({tag, "_wall"}, bx | by);
        startOfFrame = 1; @(posedge clk); #1; startOfFrame = 0;
        check(wall);
        check_pos(tag);
        @(posedge clk); #1;
        push({tag, "_wall_end"}, 0);
        check(wall);
    endtask

    task automatic do_strike(input string tag, input int vx, input int vy, input bit with_frame);
        if (!m_moving && !m_pocketed) begin
            m_vx = clampv(vx); m_vy = clampv(vy);
            m_moving = (m_vx != 0 || m_vy != 0);
        end
        sx = 11'(vx); sy = 11'(vy); strike = 1; startOfFrame = with_frame;
        @(posedge clk); #1;
        strike = 0; startOfFrame = 0;
        check_pos(tag);
    endtask

    initial begin
        resetN = 0; startOfFrame = 0; strike = 0; pocket = 0; respawn = 0;
        strike2 = 0; sx = 0; sy = 0; sx2 = 0; sy2 = 0;
        model_reset();
        #12;
        push("inreset_wall", 0); check(wall);
        check_pos("inreset");
        #10 resetN = 1;
        @(posedge clk); #1;
        check_pos("reset_release");

        // long glide along X until friction stops it
        do_strike("strike128", 128, 0, 0);
        for (int i = 1; i <= 70; i++) begin
            do_frame($sformatf("glide_f%0d", i));
            if (i == 63) begin push("moving_f63", 1); check(moving); end
            if (i == 64) begin push("moving_f64", 0); check(moving); end
        end
        push("glide_final_x", 365); check(px);

        // strike wins over a coincident frame pulse
        do_strike("strike_sof", 0, -50, 1);
        for (int i = 1; i <= 30; i++) do_frame($sformatf("sofrun_f%0d", i));

        // full-speed shot with clamp on Y load, bouncing until rest
        do_strike("strike_max", 1023, -1024, 0);
        for (int i = 0; i < 700 && m_moving; i++) do_frame($sformatf("maxrun_f%0d", i));
        push("maxrun_stopped", 0); check(moving);

        // pocket beats a coincident frame, strikes and frames ignored while pocketed
        do_strike("strike_pk", 300, 200, 0);
        do_frame("pk_f1");
        do_frame("pk_f2");
        m_moving = 0; m_pocketed = 1; m_vx = 0; m_vy = 0;
        pocket = 1; startOfFrame = 1; @(posedge clk); #1; pocket = 0; startOfFrame = 0;
        check_pos("pocketed");
        do_strike("strike_in_pocket", 200, 200, 0);
        do_frame("pocket_frame");
        respawn = 1; @(posedge clk); #1; respawn = 0;
        m_pocketed = 0; m_px = 300 * 64; m_py = 200 * 64;
        check_pos("respawned");

        // asynchronous reset in the middle of motion
        do_strike("strike_rst", 500, 500, 0);
        do_frame("rst_f1");
        do_frame("rst_f2");
        #2 resetN = 0;
        #1;
        model_reset();
        check_pos("async_reset");
        @(posedge clk); #2 resetN = 1;
        @(posedge clk); #1;

        // left-wall clamp and speed reversal on the second instance
        push("d2_start_x", 50); check(px2);
        sx2 = -11'sd1023; sy2 = 0; strike2 = 1; @(posedge clk); #1; strike2 = 0;
        push("d2_moving", 1); check(moving2);
        startOfFrame = 1; @(posedge clk); #1; startOfFrame = 0;
        push("d2_clamp_x", 40); check(px2);
        push("d2_wall", 1); check(wall2);
        @(posedge clk); #1;
        push("d2_wall_end", 0); check(wall2);
        startOfFrame = 1; @(posedge clk); #1; startOfFrame = 0;
        push("d2_rebound_x", 55); check(px2);
        push("d2_rebound_wall", 0); check(wall2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
